// File: rtl/rr_ast_pkt_mux.sv
// rr_ast_pkt_mux: packet-aware N:1 Avalon-ST mux, round-robin or fixed-priority, 2-entry output buffer
// Ports: clk_i/srst_i clock and sync active-high reset; ast_sink_* per-channel Avalon-ST sinks
// (data, valid, ready, empty, sop, eop); ast_source_* merged Avalon-ST source plus channel tag.
module rr_ast_pkt_mux #(
    parameter int BYTE_W      = 8,
    parameter int IN_DIRS_CNT = 8,
    parameter int AST_SYMBOLS = 1,
    parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS),
    parameter int ARB_MODE    = 1,
    parameter int CHAN_W      = (IN_DIRS_CNT == 1) ? 1 : $clog2(IN_DIRS_CNT)
) (
    input  logic                                                clk_i,
    input  logic                                                srst_i,
    input  logic [IN_DIRS_CNT-1:0][AST_SYMBOLS-1:0][BYTE_W-1:0] ast_sink_data_i,
    output logic [IN_DIRS_CNT-1:0]                              ast_sink_ready_o,
    input  logic [IN_DIRS_CNT-1:0]                              ast_sink_valid_i,
    input  logic [IN_DIRS_CNT-1:0][AST_EMPTY_W-1:0]             ast_sink_empty_i,
    input  logic [IN_DIRS_CNT-1:0]                              ast_sink_endofpacket_i,
    input  logic [IN_DIRS_CNT-1:0]                              ast_sink_startofpacket_i,
    output logic [AST_SYMBOLS-1:0][BYTE_W-1:0]                  ast_source_data_o,
    input  logic                                                ast_source_ready_i,
    output logic                                                ast_source_valid_o,
    output logic [AST_EMPTY_W-1:0]                              ast_source_empty_o,
    output logic                                                ast_source_endofpacket_o,
    output logic                                                ast_source_startofpacket_o,
    output logic [CHAN_W-1:0]                                   ast_source_channel_o
);
    typedef enum logic {IDLE, LOCKED} state_e;
    typedef struct packed {
        logic [AST_SYMBOLS-1:0][BYTE_W-1:0] data;
        logic [AST_EMPTY_W-1:0]             empty;
        logic                               sop;
        logic                               eop;
        logic [CHAN_W-1:0]                  chan;
    } beat_t;
    state_e      state_q, state_d;
    logic [CHAN_W-1:0] sel_q, sel_d, last_grant_q, last_grant_d, winner;
    logic [1:0]  cnt_q, cnt_d;
    beat_t       head_q, head_d, tail_q, tail_d, in_beat;
    logic        full, push, pop;
    // Descending scan so the last hit is the highest-priority candidate.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int i = IN_DIRS_CNT; i >= 1; i--) begin
            idx = (ARB_MODE != 0) ? (int'(last_grant_q) + i) % IN_DIRS_CNT : i - 1;
            if (ast_sink_valid_i[idx])
                winner = CHAN_W'(idx);
        end
    end
    // Sink ready looks only at registered state, keeping source ready off the sink-ready path.
    always_comb begin
        full             = cnt_q == 2'd2;
        ast_sink_ready_o = '0;
        if (state_q == LOCKED)
            ast_sink_ready_o[sel_q] = !full;
        push          = state_q == LOCKED && ast_sink_valid_i[sel_q] && !full;
        pop           = cnt_q != 2'd0 && ast_source_ready_i;
        in_beat.data  = ast_sink_data_i[sel_q];
        in_beat.empty = ast_sink_empty_i[sel_q];
        in_beat.sop   = ast_sink_startofpacket_i[sel_q];
        in_beat.eop   = ast_sink_endofpacket_i[sel_q];
        in_beat.chan  = sel_q;
        state_d       = state_q;
        sel_d         = sel_q;
        last_grant_d  = last_grant_q;
        if (state_q == IDLE && |ast_sink_valid_i) begin
            sel_d   = winner;
            state_d = LOCKED;
        end else if (push && in_beat.eop) begin
            last_grant_d = sel_q;
            state_d      = IDLE;
        end
        // Shift-register FIFO: head is always the oldest entry.
        head_d = pop ? tail_q : head_q;
        tail_d = tail_q;
        if (push) begin
            if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))
                head_d = in_beat;
            else
                tail_d = in_beat;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= CHAN_W'(IN_DIRS_CNT - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end
    assign ast_source_valid_o         = cnt_q != 2'd0;
    assign ast_source_data_o          = head_q.data;
    assign ast_source_empty_o         = head_q.empty;
    assign ast_source_startofpacket_o = head_q.sop;
    assign ast_source_endofpacket_o   = head_q.eop;
    assign ast_source_channel_o       = head_q.chan;
endmodule

// File: tb/tb_rr_ast_pkt_mux.sv
// tb_rr_ast_pkt_mux: directed self-checking bench for rr_ast_pkt_mux (round-robin and fixed-priority instances)
module tb_rr_ast_pkt_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic srst;
    logic [3:0][0:0][7:0] r_data;
    logic [3:0]           r_ready, r_valid, r_sop, r_eop, r_hs;
    logic [3:0][0:0]      r_empty;
    logic [0:0][7:0]      r_odata;
    logic                 r_oready, r_ovalid, r_osop, r_oeop;
    logic [0:0]           r_oempty;
    logic [1:0]           r_ochan;
    logic [7:0][0:0][7:0] f_data;
    logic [7:0]           f_ready, f_valid, f_sop, f_eop, f_hs;
    logic [7:0][0:0]      f_empty;
    logic [0:0][7:0]      f_odata;
    logic                 f_oready, f_ovalid, f_osop, f_oeop;
    logic [0:0]           f_oempty;
    logic [2:0]           f_ochan;
    rr_ast_pkt_mux #(.BYTE_W(8), .IN_DIRS_CNT(4), .AST_SYMBOLS(1), .ARB_MODE(1)) dut_rr (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(r_data), .ast_sink_ready_o(r_ready), .ast_sink_valid_i(r_valid),
        .ast_sink_empty_i(r_empty), .ast_sink_endofpacket_i(r_eop), .ast_sink_startofpacket_i(r_sop),
        .ast_source_data_o(r_odata), .ast_source_ready_i(r_oready), .ast_source_valid_o(r_ovalid),
        .ast_source_empty_o(r_oempty), .ast_source_endofpacket_o(r_oeop),
        .ast_source_startofpacket_o(r_osop), .ast_source_channel_o(r_ochan)
    );
    rr_ast_pkt_mux #(.BYTE_W(8), .IN_DIRS_CNT(8), .AST_SYMBOLS(1), .ARB_MODE(0)) dut_fp (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(f_data), .ast_sink_ready_o(f_ready), .ast_sink_valid_i(f_valid),
        .ast_sink_empty_i(f_empty), .ast_sink_endofpacket_i(f_eop), .ast_sink_startofpacket_i(f_sop),
        .ast_source_data_o(f_odata), .ast_source_ready_i(f_oready), .ast_source_valid_o(f_ovalid),
        .ast_source_empty_o(f_oempty), .ast_source_endofpacket_o(f_oeop),
        .ast_source_startofpacket_o(f_osop), .ast_source_channel_o(f_ochan)
    );
    typedef struct {
        int d;
        int ch;
        int s;
        int e;
        int m;
        int cyc;
    } rec_t;
    rec_t rlog[$];
    rec_t flog[$];
    int r_left[4], r_idx[4], r_len[4];
    int f_left[8], f_idx[8], f_len[8];
    int cyc, checks, failures;
    logic seen5;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    // One clock cycle: inputs change at the falling edge, handshakes and outputs sampled 1ns later.
    task automatic step(input logic rst, input logic ordy);
        @(negedge clk);
        for (int c = 0; c < 4; c++) if (r_hs[c]) begin r_idx[c]++; r_left[c]--; end
        for (int c = 0; c < 8; c++) if (f_hs[c]) begin f_idx[c]++; f_left[c]--; end
        srst = rst;
        r_oready = ordy;
        f_oready = ordy;
        for (int c = 0; c < 4; c++) begin
            r_valid[c]    = r_left[c] > 0;
            r_data[c][0]  = 8'(c * 32 + r_idx[c]);
            r_sop[c]      = (r_idx[c] % r_len[c]) == 0;
            r_eop[c]      = (r_idx[c] % r_len[c]) == r_len[c] - 1;
            r_empty[c][0] = 1'(r_idx[c] % 2);
        end
        for (int c = 0; c < 8; c++) begin
            f_valid[c]    = f_left[c] > 0;
            f_data[c][0]  = 8'(c * 32 + f_idx[c]);
            f_sop[c]      = (f_idx[c] % f_len[c]) == 0;
            f_eop[c]      = (f_idx[c] % f_len[c]) == f_len[c] - 1;
            f_empty[c][0] = 1'(f_idx[c] % 2);
        end
        #1;
        r_hs = r_valid & r_ready;
        f_hs = f_valid & f_ready;
        if (r_ovalid && r_oready)
            rlog.push_back('{d: int'(r_odata[0]), ch: int'(r_ochan), s: int'(r_osop), e: int'(r_oeop), m: int'(r_oempty), cyc: cyc});
        if (f_ovalid && f_oready)
            flog.push_back('{d: int'(f_odata[0]), ch: int'(f_ochan), s: int'(f_osop), e: int'(f_oeop), m: int'(f_oempty), cyc: cyc});
        cyc++;
    endtask
    initial begin
        int chs[3];
        int p;
        chs = '{0, 1, 3};
        srst = 1'b1;
        r_oready = 1'b1;
        f_oready = 1'b1;
        r_data = '0; r_valid = '0; r_sop = '0; r_eop = '0; r_empty = '0; r_hs = '0;
        f_data = '0; f_valid = '0; f_sop = '0; f_eop = '0; f_empty = '0; f_hs = '0;
        for (int c = 0; c < 4; c++) begin r_left[c] = 0; r_idx[c] = 0; r_len[c] = 1; end
        for (int c = 0; c < 8; c++) begin f_left[c] = 0; f_idx[c] = 0; f_len[c] = 1; end
        cyc = 0; checks = 0; failures = 0;
        // reset then idle
        for (int i = 0; i < 5; i++) begin
            step(i < 2, 1'b1);
            chk("rst_rr_valid", r_ovalid, 0);
            chk("rst_rr_ready", r_ready, 0);
            chk("rst_fp_valid", f_ovalid, 0);
            chk("rst_fp_ready", f_ready, 0);
        end
        // round-robin interleave: channels 0, 1, 3 each two 3-beat packets
        for (int c = 0; c < 4; c++) if (c != 2) begin r_left[c] = 6; r_len[c] = 3; r_idx[c] = 0; end
        rlog.delete();
        for (int i = 0; i < 80 && rlog.size() < 18; i++) step(1'b0, 1'b1);
        chk("rr_count", rlog.size(), 18);
        for (int k = 0; k < rlog.size() && k < 18; k++) begin
            p = chs[(k / 3) % 3];
            chk("rr_data", rlog[k].d, p * 32 + (k / 9) * 3 + k % 3);
            chk("rr_chan", rlog[k].ch, p);
            chk("rr_sop", rlog[k].s, (k % 3) == 0);
            chk("rr_eop", rlog[k].e, (k % 3) == 2);
            if (k > 0)
                chk("rr_gap", rlog[k].cyc - rlog[k-1].cyc, (k % 3) == 0 ? 2 : 1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        // backpressure: 6-beat packet on channel 2, source stalled for cycles 3-7
        r_left[2] = 6; r_len[2] = 6; r_idx[2] = 0;
        rlog.delete();
        for (int t = 0; t < 12; t++) begin
            step(1'b0, !(t >= 3 && t <= 7));
            chk("bp_ready", r_ready[2], (t == 0 || (t >= 4 && t <= 8)) ? 0 : 1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("bp_count", rlog.size(), 6);
        for (int k = 0; k < rlog.size() && k < 6; k++) begin
            chk("bp_data", rlog[k].d, 64 + k);
            chk("bp_sop", rlog[k].s, k == 0);
            chk("bp_eop", rlog[k].e, k == 5);
            chk("bp_chan", rlog[k].ch, 2);
        end
        // single-beat packets on channel 1
        r_left[1] = 4; r_len[1] = 1; r_idx[1] = 0;
        rlog.delete();
        for (int i = 0; i < 30 && rlog.size() < 4; i++) step(1'b0, 1'b1);
        chk("sb_count", rlog.size(), 4);
        for (int k = 0; k < rlog.size() && k < 4; k++) begin
            chk("sb_data", rlog[k].d, 32 + k);
            chk("sb_sopeop", rlog[k].s + rlog[k].e, 2);
            chk("sb_empty", rlog[k].m, k % 2);
            chk("sb_chan", rlog[k].ch, 1);
            if (k > 0)
                chk("sb_gap", rlog[k].cyc - rlog[k-1].cyc, 2);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        // reset on beat 3 of a 5-beat packet on channel 2
        r_left[2] = 5; r_len[2] = 5; r_idx[2] = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("mr_locked", r_ready[2], 1);
        step(1'b1, 1'b1);
        r_left[0] = 3; r_len[0] = 3; r_idx[0] = 0;
        step(1'b0, 1'b1);
        chk("mr_valid", r_ovalid, 0);
        chk("mr_ready", r_ready, 0);
        rlog.delete();
        for (int i = 0; i < 10 && rlog.size() < 1; i++) step(1'b0, 1'b1);
        chk("mr_count", rlog.size(), 1);
        if (rlog.size() > 0) begin
            chk("mr_chan", rlog[0].ch, 0);
            chk("mr_data", rlog[0].d, 0);
            chk("mr_sop", rlog[0].s, 1);
        end
        // fixed priority: channels 2 and 5 continuously valid with 2-beat packets
        f_left[2] = 1000; f_len[2] = 2; f_idx[2] = 0;
        f_left[5] = 1000; f_len[5] = 2; f_idx[5] = 0;
        flog.delete();
        seen5 = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 1'b1);
            if (f_ready[5]) seen5 = 1'b1;
        end
        chk("fp_count_ok", flog.size() >= 10, 1);
        chk("fp_ready5", seen5, 0);
        for (int k = 0; k < flog.size(); k++) begin
            chk("fp_chan", flog[k].ch, 2);
            chk("fp_data", flog[k].d, 64 + k);
            chk("fp_sop", flog[k].s, (k % 2) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
